// File: rtl/ldpc_lane_seq_if.sv
// ----------------------------------------------------------------------------
// ldpc_lane_seq_if
//   Bundles the request, response and ALU-facing signals of the packed-int8
//   LDPC sequencer.
//
//   master : execute-stage side (request producer, result consumer, and the
//            integer ALU that answers the sequencer's scalar issues)
//   slave  : the sequencer itself
//
//   Signals
//     flush                         drop any in-flight op
//     req_valid / req_ready         request handshake
//     req_operator                  LDPC operator code
//     req_operand_a / req_operand_b packed lanes, lane k = bits [8k+7:8k]
//     req_trans_id                  scoreboard tag of the request
//     rsp_valid / rsp_ready         result handshake
//     rsp_result                    repacked 32-bit result
//     rsp_trans_id                  tag of the result
//     rsp_sat                       lane saturation flag (LDPC_SEQ_SAT_FLAG_EN only)
//     alu_fu .. alu_trans_id        fu_data fields driven into the ALU
//     alu_result                    ALU result_o
//
//   Optional feature macro: LDPC_SEQ_SAT_FLAG_EN adds rsp_sat.
// ----------------------------------------------------------------------------
interface ldpc_lane_seq_if #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned OP_BITS       = 8,
  parameter int unsigned FU_BITS       = 4
);
  logic                     flush;

  logic                     req_valid;
  logic                     req_ready;
  logic [OP_BITS-1:0]       req_operator;
  logic [31:0]              req_operand_a;
  logic [31:0]              req_operand_b;
  logic [TRANS_ID_BITS-1:0] req_trans_id;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_result;
  logic [TRANS_ID_BITS-1:0] rsp_trans_id;
`ifdef LDPC_SEQ_SAT_FLAG_EN
  logic                     rsp_sat;
`endif

  logic [FU_BITS-1:0]       alu_fu;
  logic [OP_BITS-1:0]       alu_operator;
  logic [XLEN-1:0]          alu_operand_a;
  logic [XLEN-1:0]          alu_operand_b;
  logic [XLEN-1:0]          alu_imm;
  logic [TRANS_ID_BITS-1:0] alu_trans_id;
  logic [XLEN-1:0]          alu_result;

`ifdef LDPC_SEQ_SAT_FLAG_EN
  modport master (
    output flush, req_valid, req_operator, req_operand_a, req_operand_b, req_trans_id,
    output rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_trans_id, rsp_sat,
    input  alu_fu, alu_operator, alu_operand_a, alu_operand_b, alu_imm, alu_trans_id
  );

  modport slave (
    input  flush, req_valid, req_operator, req_operand_a, req_operand_b, req_trans_id,
    input  rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_trans_id, rsp_sat,
    output alu_fu, alu_operator, alu_operand_a, alu_operand_b, alu_imm, alu_trans_id
  );
`else
  modport master (
    output flush, req_valid, req_operator, req_operand_a, req_operand_b, req_trans_id,
    output rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_trans_id,
    input  alu_fu, alu_operator, alu_operand_a, alu_operand_b, alu_imm, alu_trans_id
  );

  modport slave (
    input  flush, req_valid, req_operator, req_operand_a, req_operand_b, req_trans_id,
    input  rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_trans_id,
    output alu_fu, alu_operator, alu_operand_a, alu_operand_b, alu_imm, alu_trans_id
  );
`endif
endinterface

// File: rtl/ldpc_lane_seq.sv
// ----------------------------------------------------------------------------
// ldpc_lane_seq
//   Packed-int8 LDPC sequencer in front of the integer ALU. A lane op is
//   issued to the ALU once per int8 lane on consecutive cycles; the low byte
//   of each ALU result is captured into its lane and the repacked word is
//   returned. Any other operator is a single full-width ALU issue.
//
//   Ports
//     clk_i   clock
//     rst_ni  asynchronous reset, active low
//     bus     ldpc_lane_seq_if.slave (request, response, ALU fu_data/result)
//
//   Optional feature macro: LDPC_SEQ_SAT_FLAG_EN
//     Adds rsp_sat: set in DONE when an ADD_SAT/SUB_SAT lane's raw 9-bit
//     signed sum/difference falls outside [-127,127].
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a request, ALU inputs quiet
//   ST_ISSUE | driving the ALU; one lane per cycle (or one scalar issue)
//   ST_DONE  | result valid and held until the consumer takes it
// ----------------------------------------------------------------------------
module ldpc_lane_seq #(
  parameter int unsigned NR_LANES      = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned OP_BITS       = 8,
  parameter int unsigned FU_BITS       = 4
) (
  input logic           clk_i,
  input logic           rst_ni,
  ldpc_lane_seq_if.slave bus
);

  localparam logic [OP_BITS-1:0] OP_ADD          = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_LDPC_MIN     = OP_BITS'(100);
  localparam logic [OP_BITS-1:0] OP_LDPC_MAX     = OP_BITS'(101);
  localparam logic [OP_BITS-1:0] OP_LDPC_ABS     = OP_BITS'(102);
  localparam logic [OP_BITS-1:0] OP_LDPC_ADD_SAT = OP_BITS'(103);
  localparam logic [OP_BITS-1:0] OP_LDPC_SUB_SAT = OP_BITS'(104);
  localparam logic [OP_BITS-1:0] OP_LDPC_NMESS   = OP_BITS'(105);

  localparam logic [FU_BITS-1:0] FU_NONE = FU_BITS'(0);
  localparam logic [FU_BITS-1:0] FU_ALU  = FU_BITS'(1);

  localparam int unsigned ACC_W     = 8 * NR_LANES;
  localparam logic [1:0]  LAST_LANE = 2'(NR_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_e;

  state_e                   state_q;
  logic [OP_BITS-1:0]       op_q;
  logic                     lane_op_q;
  logic [31:0]              a_q;
  logic [31:0]              b_q;
  logic [TRANS_ID_BITS-1:0] tid_q;
  logic [1:0]               lane_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_next;
  logic                     valid_q;
  logic [31:0]              result_q;
  logic [TRANS_ID_BITS-1:0] rsp_tid_q;

  logic                     accept;
  logic [7:0]               a_byte;
  logic [7:0]               b_byte;
  logic                     unused_alu_hi;

  function automatic logic is_lane_op(input logic [OP_BITS-1:0] op);
    return (op == OP_LDPC_MIN) || (op == OP_LDPC_MAX) || (op == OP_LDPC_ABS) ||
           (op == OP_LDPC_ADD_SAT) || (op == OP_LDPC_SUB_SAT) || (op == OP_LDPC_NMESS);
  endfunction

  assign a_byte = a_q[{3'b000, lane_q, 3'b000} +: 8];
  assign b_byte = b_q[{3'b000, lane_q, 3'b000} +: 8];

  // Lane ops only consume the low byte, scalar ops only the low word.
  assign unused_alu_hi = ^bus.alu_result[XLEN-1:32];

  // Flush wins over a same-cycle request. In DONE a new request may be taken
  // on the same edge that the consumer takes the result.
  always_comb begin
    bus.req_ready = 1'b0;
    if (!bus.flush) begin
      bus.req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.rsp_ready);
    end
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    acc_next = acc_q;
    for (int k = 0; k < int'(NR_LANES); k++) begin
      if (lane_q == 2'(k)) begin
        acc_next[8*k +: 8] = bus.alu_result[7:0];
      end
    end
  end

  always_comb begin
    bus.alu_fu        = FU_NONE;
    bus.alu_operator  = OP_ADD;
    bus.alu_operand_a = '0;
    bus.alu_operand_b = '0;
    bus.alu_imm       = '0;
    bus.alu_trans_id  = '0;
    if (state_q == ST_ISSUE) begin
      bus.alu_fu       = FU_ALU;
      bus.alu_operator = op_q;
      bus.alu_trans_id = tid_q;
      if (lane_op_q) begin
        bus.alu_operand_a = {{(XLEN-8){1'b0}}, a_byte};
        bus.alu_operand_b = {{(XLEN-8){1'b0}}, b_byte};
      end else begin
        bus.alu_operand_a = {{(XLEN-32){1'b0}}, a_q};
        bus.alu_operand_b = {{(XLEN-32){1'b0}}, b_q};
      end
    end
  end

`ifdef LDPC_SEQ_SAT_FLAG_EN
  logic              sat_op_q;
  logic              sat_acc_q;
  logic              sat_q;
  logic signed [8:0] raw_lane;
  logic              lane_over;

  // Raw (unsaturated) lane result, sign-extended to 9 bits so it cannot wrap.
  always_comb begin
    if (op_q == OP_LDPC_SUB_SAT) begin
      raw_lane = $signed({a_byte[7], a_byte}) - $signed({b_byte[7], b_byte});
    end else begin
      raw_lane = $signed({a_byte[7], a_byte}) + $signed({b_byte[7], b_byte});
    end
    lane_over = sat_op_q && ((raw_lane > 9'sd127) || (raw_lane < -9'sd127));
  end

  assign bus.rsp_sat = sat_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      lane_op_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tid_q     <= '0;
      lane_q    <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rsp_tid_q <= '0;
`ifdef LDPC_SEQ_SAT_FLAG_EN
      sat_op_q  <= 1'b0;
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
`endif
    end else if (bus.flush) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rsp_tid_q <= '0;
`ifdef LDPC_SEQ_SAT_FLAG_EN
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_ISSUE;
        end

        ST_ISSUE: begin
`ifdef LDPC_SEQ_SAT_FLAG_EN
          sat_acc_q <= sat_acc_q | lane_over;
`endif
          if (!lane_op_q || (lane_q == LAST_LANE)) begin
            state_q   <= ST_DONE;
            valid_q   <= 1'b1;
            rsp_tid_q <= tid_q;
            result_q  <= lane_op_q ? 32'(acc_next) : bus.alu_result[31:0];
`ifdef LDPC_SEQ_SAT_FLAG_EN
            sat_q     <= sat_acc_q | lane_over;
`endif
          end else begin
            acc_q  <= acc_next;
            lane_q <= lane_q + 2'd1;
          end
        end

        ST_DONE: begin
          if (bus.rsp_ready) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            rsp_tid_q <= '0;
`ifdef LDPC_SEQ_SAT_FLAG_EN
            sat_q     <= 1'b0;
`endif
            state_q   <= accept ? ST_ISSUE : ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      if (accept) begin
        op_q      <= bus.req_operator;
        lane_op_q <= is_lane_op(bus.req_operator);
        a_q       <= bus.req_operand_a;
        b_q       <= bus.req_operand_b;
        tid_q     <= bus.req_trans_id;
        lane_q    <= '0;
        acc_q     <= '0;
`ifdef LDPC_SEQ_SAT_FLAG_EN
        sat_op_q  <= (bus.req_operator == OP_LDPC_ADD_SAT) ||
                     (bus.req_operator == OP_LDPC_SUB_SAT);
        sat_acc_q <= 1'b0;
`endif
      end
    end
  end

  assign bus.rsp_valid    = valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_trans_id = rsp_tid_q;

endmodule

// File: tb/tb_ldpc_lane_seq.sv
module tb_ldpc_lane_seq;

  localparam logic [7:0] OP_ADD     = 8'd0;
  localparam logic [7:0] OP_MIN     = 8'd100;
  localparam logic [7:0] OP_MAX     = 8'd101;
  localparam logic [7:0] OP_ABS     = 8'd102;
  localparam logic [7:0] OP_ADD_SAT = 8'd103;
  localparam logic [7:0] OP_SUB_SAT = 8'd104;
  localparam logic [7:0] OP_NMESS   = 8'd105;
  localparam logic [7:0] OP_SIGN    = 8'd106;
  localparam logic [7:0] OP_EVAL    = 8'd107;
  localparam logic [7:0] OP_RSIGN   = 8'd108;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  tid;
    logic        sat;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  ldpc_lane_seq_if bus ();

  ldpc_lane_seq dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  function automatic logic is_lane(input logic [7:0] op);
    return (op >= OP_MIN) && (op <= OP_NMESS);
  endfunction

  function automatic int clamp127(input int s);
    if (s > 127) return 127;
    if (s < -127) return -127;
    return s;
  endfunction

  function automatic logic [7:0] lane_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    int s;
    x = int'($signed(a));
    y = int'($signed(b));
    case (op)
      OP_MIN:     s = (x < y) ? x : y;
      OP_MAX:     s = (x > y) ? x : y;
      OP_ABS:     s = (x < 0) ? -x : x;
      OP_ADD_SAT: s = clamp127(x + y);
      OP_SUB_SAT: s = clamp127(x - y);
      OP_NMESS:   s = (a != 8'd0) ? y : -y;
      default:    s = 0;
    endcase
    return s[7:0];
  endfunction

  function automatic logic [31:0] scalar_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_EVAL:  return (a == b) ? 32'h0000_00FF : 32'h0;
      OP_SIGN:  return a ^ b;
      OP_RSIGN: return ~a;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic [31:0] word_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (!is_lane(op)) return scalar_ref(op, a, b);
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = lane_ref(op, a[8*k +: 8], b[8*k +: 8]);
    return r;
  endfunction

  function automatic logic sat_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic f;
    int   s;
    f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (op == OP_ADD_SAT) s = int'($signed(a[8*k +: 8])) + int'($signed(b[8*k +: 8]));
      else                  s = int'($signed(a[8*k +: 8])) - int'($signed(b[8*k +: 8]));
      if (((op == OP_ADD_SAT) || (op == OP_SUB_SAT)) && ((s > 127) || (s < -127))) f = 1'b1;
    end
    return f;
  endfunction

  // Behavioural ALU: lane ops answer in the low byte with junk above it,
  // scalar ops answer in the low word with junk in the upper word.
  always_comb begin
    if (is_lane(bus.alu_operator)) begin
      bus.alu_result = {56'hA5A5_A5A5_A5A5_A5, lane_ref(bus.alu_operator, bus.alu_operand_a[7:0], bus.alu_operand_b[7:0])};
    end else begin
      bus.alu_result = {32'hDEAD_BEEF, scalar_ref(bus.alu_operator, bus.alu_operand_a[31:0], bus.alu_operand_b[31:0])};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [2:0] tid, input logic sat);
    exp_t e;
    e.res = res;
    e.tid = tid;
    e.sat = sat;
    sb.push_back(e);
  endtask

  // Drives one request and returns #1 after the accepting edge.
  task automatic start_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] tid);
    bus.req_operator  = op;
    bus.req_operand_a = a;
    bus.req_operand_b = b;
    bus.req_trans_id  = tid;
    bus.req_valid     = 1'b1;
    #1;
    check("req_ready_at_accept", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk_i);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.rsp_valid && (n < 20)) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("result", {32'd0, bus.rsp_result}, {32'd0, e.res});
      check("trans_id", {61'd0, bus.rsp_trans_id}, {61'd0, e.tid});
`ifdef LDPC_SEQ_SAT_FLAG_EN
      check("sat", {63'd0, bus.rsp_sat}, {63'd0, e.sat});
`endif
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk_i);
    #1;
    check("valid_after_consume", {63'd0, bus.rsp_valid}, 64'd0);
    check("ready_after_consume", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] tid, input logic [31:0] res, input logic sat);
    push_exp(res, tid, sat);
    start_op(op, a, b, tid);
    wait_valid(is_lane(op) ? 4 : 1);
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    logic [7:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [7:0]  op_list [6];

    bus.flush         = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_operator  = OP_ADD;
    bus.req_operand_a = '0;
    bus.req_operand_b = '0;
    bus.req_trans_id  = '0;
    bus.rsp_ready     = 1'b1;

    #12;
    check("rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_result", {32'd0, bus.rsp_result}, 64'd0);
    check("rst_trans_id", {61'd0, bus.rsp_trans_id}, 64'd0);
    check("rst_alu_op", {56'd0, bus.alu_operator}, {56'd0, OP_ADD});
`ifdef LDPC_SEQ_SAT_FLAG_EN
    check("rst_sat", {63'd0, bus.rsp_sat}, 64'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_op(OP_ADD_SAT, 32'h7F05FC80, 32'h0103FCFF, 3'd1, 32'h7F08F881, 1'b1);
    run_op(OP_MIN,     32'h10F00580, 32'h2010FB7F, 3'd2, 32'h10F0FB80, 1'b0);
    run_op(OP_ABS,     32'h808100FF, 32'h00000000, 3'd3, 32'h807F0001, 1'b0);
    run_op(OP_MAX,     32'h10F00580, 32'h2010FB7F, 3'd4, 32'h2010057F, 1'b0);
    run_op(OP_NMESS,   32'h00FF0100, 32'h05FB807F, 3'd5, 32'hFBFB8081, 1'b0);
    run_op(OP_SUB_SAT, 32'h807F0010, 32'h01FF7F20, 3'd6, 32'h817F81F0, 1'b1);
    run_op(OP_EVAL,    32'h00000005, 32'h00000005, 3'd7, 32'h000000FF, 1'b0);
    run_op(OP_SIGN,    32'h12345678, 32'hFF00FF00, 3'd0, 32'hED34A978, 1'b0);

    // Consumer stalls for 10 cycles, then takes the result while a new
    // request is presented on the same edge.
    bus.rsp_ready = 1'b0;
    push_exp(32'h04030304, 3'd6, 1'b0);
    start_op(OP_MAX, 32'h01020304, 32'h04030201, 3'd6);
    wait_valid(4);
    held_res = 32'h04030304;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      check("hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("hold_result", {32'd0, bus.rsp_result}, {32'd0, held_res});
      check("hold_trans_id", {61'd0, bus.rsp_trans_id}, 64'd6);
      check("hold_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    push_exp(32'h03030303, 3'd7, 1'b0);
    start_op(OP_ADD_SAT, 32'h01010101, 32'h02020202, 3'd7);
    check("b2b_valid_dropped", {63'd0, bus.rsp_valid}, 64'd0);
    check("b2b_alu_issuing", {56'd0, bus.alu_operator}, {56'd0, OP_ADD_SAT});
    wait_valid(4);
    consume();

    // Flush while lane 2 is being issued.
    start_op(OP_MIN, 32'hAABBCCDD, 32'h00000000, 3'd5);
    @(posedge clk_i);
    #1;
    check("lane1_fu", {60'd0, bus.alu_fu}, 64'd1);
    check("lane1_operand_a", bus.alu_operand_a, 64'h00000000000000CC);
    check("lane1_operand_b", bus.alu_operand_b, 64'd0);
    check("lane1_trans_id", {61'd0, bus.alu_trans_id}, 64'd5);
    @(posedge clk_i);
    #1;
    check("lane2_operand_a", bus.alu_operand_a, 64'h00000000000000BB);
    bus.flush = 1'b1;
    @(posedge clk_i);
    #1;
    bus.flush = 1'b0;
    #1;
    check("flush_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("flush_ready", {63'd0, bus.req_ready}, 64'd1);
    check("flush_alu_op", {56'd0, bus.alu_operator}, {56'd0, OP_ADD});
    check("flush_alu_a", bus.alu_operand_a, 64'd0);
    check("flush_alu_b", bus.alu_operand_b, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      check("flush_no_valid", {63'd0, bus.rsp_valid}, 64'd0);
    end

    // Flush beats a same-cycle request.
    bus.req_operator  = OP_MAX;
    bus.req_operand_a = 32'h11111111;
    bus.req_operand_b = 32'h22222222;
    bus.req_valid     = 1'b1;
    bus.flush         = 1'b1;
    @(posedge clk_i);
    #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check("flush_vs_valid_alu_op", {56'd0, bus.alu_operator}, {56'd0, OP_ADD});
    check("flush_vs_valid_ready", {63'd0, bus.req_ready}, 64'd1);

    // Async reset in the middle of ISSUE.
    start_op(OP_ADD_SAT, 32'h7F7F7F7F, 32'h01010101, 3'd2);
    @(posedge clk_i);
    #1;
    check("pre_rst_ready", {63'd0, bus.req_ready}, 64'd0);
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("midrst_ready", {63'd0, bus.req_ready}, 64'd1);
    check("midrst_result", {32'd0, bus.rsp_result}, 64'd0);
    check("midrst_trans_id", {61'd0, bus.rsp_trans_id}, 64'd0);
    check("midrst_alu_op", {56'd0, bus.alu_operator}, {56'd0, OP_ADD});
    check("midrst_alu_a", bus.alu_operand_a, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_op(OP_SUB_SAT, 32'h05050505, 32'h06060606, 3'd3, 32'hFFFFFFFF, 1'b0);

    op_list[0] = OP_MIN;
    op_list[1] = OP_MAX;
    op_list[2] = OP_ABS;
    op_list[3] = OP_ADD_SAT;
    op_list[4] = OP_SUB_SAT;
    op_list[5] = OP_RSIGN;
    for (int i = 0; i < 8; i++) begin
      rop = op_list[$urandom_range(0, 5)];
      ra  = $urandom;
      rb  = $urandom;
      run_op(rop, ra, rb, 3'(i), word_ref(rop, ra, rb), sat_ref(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
